// File: rtl/contador_pkg.sv
// Shared constants for the contador_nbits counter family: default geometry and
// the BCD digit geometry used by display counters.
package contador_pkg;

   localparam int WIDTH_DEF  = 4;
   localparam int MODULO_DEF = 2 ** WIDTH_DEF;

   localparam int BCD_WIDTH  = 4;
   localparam int BCD_MODULO = 10;

   // True when MODULO lies in the usable range for a WIDTH-bit counter.
   function automatic bit modulo_ok(input int width, input int modulo);
      return (width >= 1) && (modulo >= 2) && (modulo <= (2 ** width));
   endfunction

endpackage

// File: rtl/contador_nbits_if.sv
// Control/status bundle of contador_nbits. The `up` direction signal exists
// only when CONTADOR_UPDOWN_EN is defined.
interface contador_nbits_if
   import contador_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);
   logic             en;
   logic             load;
   logic [WIDTH-1:0] load_val;
`ifdef CONTADOR_UPDOWN_EN
   logic             up;
`endif
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrap;

`ifdef CONTADOR_UPDOWN_EN
   modport master (output en, load, load_val, up, input q, tc, wrap);
   modport slave  (input en, load, load_val, up, output q, tc, wrap);
`else
   modport master (output en, load, load_val, input q, tc, wrap);
   modport slave  (input en, load, load_val, output q, tc, wrap);
`endif

endinterface

// File: rtl/t_ff_sync.sv
// T flip-flop with synchronous active-high reset and synchronous load;
// priority is rst > load > toggle.
module t_ff_sync (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic d,
   input  logic t,
   output logic q
);

   always_ff @(posedge clk) begin
      if (rst)
         q <= 1'b0;
      else if (load)
         q <= d;
      else if (t)
         q <= ~q;
   end

endmodule

// File: rtl/contador_nbits.sv
// WIDTH-bit synchronous modulo counter built from one T flip-flop per bit.
// Define CONTADOR_UPDOWN_EN to compile in the `up` port and down counting.
module contador_nbits
   import contador_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int MODULO = 2 ** WIDTH
) (
   input  logic clk,
   input  logic rst,
   contador_nbits_if.slave bus
);

   localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MODULO);
   localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(MODULO - 1);

   logic [WIDTH-1:0] q_int;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] ff_d;
   logic [WIDTH-1:0] tgl;
   logic [WIDTH-1:0] carry_src;
   logic [WIDTH-1:0] low_mask;
   logic             at_term;
   logic             wrap_step;
   logic             ff_load;
   logic             wrap_r;

   assign load_clamped = ({1'b0, bus.load_val} >= MOD_W) ? TERM_UP : bus.load_val;

`ifdef CONTADOR_UPDOWN_EN
   assign at_term   = bus.up ? (q_int == TERM_UP) : (q_int == '0);
   assign carry_src = bus.up ? q_int : ~q_int;
`else
   assign at_term   = (q_int == TERM_UP);
   assign carry_src = q_int;
`endif

   // Wraps (and the natural rollover) go through the synchronous load path,
   // so the toggle chain only has to handle in-range steps.
   assign wrap_step = bus.en & ~bus.load & at_term;
   assign ff_load   = bus.load | wrap_step;

   always_comb begin
      ff_d = '0;
      if (bus.load)
         ff_d = load_clamped;
`ifdef CONTADOR_UPDOWN_EN
      else if (!bus.up)
         ff_d = TERM_UP;
`endif
   end

   // Bit i toggles when every lower bit is 1 (up) or 0 (down).
   always_comb begin
      tgl      = '0;
      low_mask = '0;
      for (int i = 0; i < WIDTH; i++) begin
         low_mask = WIDTH'((64'd1 << i) - 64'd1);
         tgl[i]   = bus.en & ((carry_src & low_mask) == low_mask);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      t_ff_sync u_bit (
         .clk  (clk),
         .rst  (rst),
         .load (ff_load),
         .d    (ff_d[i]),
         .t    (tgl[i]),
         .q    (q_int[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst)
         wrap_r <= 1'b0;
      else
         wrap_r <= wrap_step;
   end

   assign bus.q    = q_int;
   assign bus.wrap = wrap_r;
   assign bus.tc   = bus.en & ~bus.load & ~rst & at_term;

endmodule
